// File: rtl/updown_pkg.sv
// Shared definitions for the up/down counter.
//   dir_e     : encoding of the last-action indicator (IDLE/UP/DOWN/LOAD)
//   MODE_WRAP : boundary events wrap around
//   MODE_SAT  : boundary events clamp to the bound
package updown_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10,
    DIR_LOAD = 2'b11
  } dir_e;

endpackage

// File: rtl/updown_next.sv
// Combinational next-count and boundary detection.
// Ports:
//   count, max_val, load_val : current count, upper bound, load value
//   up, down, load           : action requests (load > up > down > hold)
//   next_count               : count to register on the next edge
//   up_evt, down_evt         : upper / lower boundary event this cycle
//   action                   : action applied this cycle
module updown_next
  import updown_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_WRAP
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_val,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  output logic [WIDTH-1:0] next_count,
  output logic             up_evt,
  output logic             down_evt,
  output dir_e             action
);

  always_comb begin
    next_count = count;
    up_evt     = 1'b0;
    down_evt   = 1'b0;
    action     = DIR_IDLE;
    if (load) begin
      // Load is taken verbatim, even above max_val.
      next_count = load_val;
      action     = DIR_LOAD;
    end else if (up) begin
      action = DIR_UP;
      // >= also catches a loaded value above the bound, and max_val==0.
      if (count < max_val) begin
        next_count = count + 1'b1;
      end else begin
        up_evt     = 1'b1;
        next_count = (MODE == MODE_SAT) ? max_val : '0;
      end
    end else if (down) begin
      action = DIR_DOWN;
      if (count != '0) begin
        next_count = count - 1'b1;
      end else begin
        down_evt   = 1'b1;
        next_count = (MODE == MODE_SAT) ? '0 : max_val;
      end
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Loadable up/down counter with programmable upper bound, wrap or
// saturate boundary handling, terminal-count pulses and a sticky flag.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   up, down, load      : action requests (load > up > down > hold)
//   load_val, max_val   : load value, upper bound (sampled every cycle)
//   clr_ovf             : clears ovf (a same-cycle boundary event wins)
//   count               : registered count
//   tc_up, tc_down      : registered one-cycle boundary pulses
//   ovf                 : sticky boundary flag
//   dir                 : last action, 00 IDLE 01 UP 10 DOWN 11 LOAD
module updown_counter_n
  import updown_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc_up,
  output logic             tc_down,
  output logic             ovf,
  output logic [1:0]       dir
);

  logic [WIDTH-1:0] next_count;
  logic             up_evt;
  logic             down_evt;
  dir_e             action;
  dir_e             state_q;
  dir_e             state_d;

  updown_next #(.WIDTH(WIDTH), .MODE(MODE)) u_next (
    .count      (count),
    .max_val    (max_val),
    .load_val   (load_val),
    .up         (up),
    .down       (down),
    .load       (load),
    .next_count (next_count),
    .up_evt     (up_evt),
    .down_evt   (down_evt),
    .action     (action)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      tc_up   <= 1'b0;
      tc_down <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      count   <= next_count;
      tc_up   <= up_evt;
      tc_down <= down_evt;
      if (up_evt || down_evt) ovf <= 1'b1;
      else if (clr_ovf)       ovf <= 1'b0;
    end
  end

  // dir FSM: every edge jumps to the state of the action just applied.
  always_ff @(posedge clk) begin
    if (reset) state_q <= DIR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = DIR_IDLE;
    case (action)
      DIR_UP:   state_d = DIR_UP;
      DIR_DOWN: state_d = DIR_DOWN;
      DIR_LOAD: state_d = DIR_LOAD;
      default:  state_d = DIR_IDLE;
    endcase
  end

  assign dir = state_q;

endmodule

// File: tb/tb_updown_counter_n.sv
module tb_updown_counter_n;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0, up = 1'b0, down = 1'b0, load = 1'b0, clr_ovf = 1'b0;
  logic [W-1:0] load_val = '0, max_val = '0;

  logic [W-1:0] cnt0, cnt1;
  logic         tcu0, tcu1, tcd0, tcd1, ovf0, ovf1;
  logic [1:0]   dir0, dir1;

  int n_chk = 0, n_err = 0;

  // reference state, index 0 = wrap instance, 1 = saturate instance
  int m_cnt[2], m_tcu[2], m_tcd[2], m_ovf[2], m_dir[2];

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(W), .MODE(0)) d0 (
    .clk(clk), .reset(reset), .up(up), .down(down), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .count(cnt0), .tc_up(tcu0), .tc_down(tcd0), .ovf(ovf0), .dir(dir0));

  updown_counter_n #(.WIDTH(W), .MODE(1)) d1 (
    .clk(clk), .reset(reset), .up(up), .down(down), .load(load),
    .load_val(load_val), .max_val(max_val), .clr_ovf(clr_ovf),
    .count(cnt1), .tc_up(tcu1), .tc_down(tcd1), .ovf(ovf1), .dir(dir1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: one action per cycle, computed from the bound rules.
  task automatic model(input int m);
    int mv, lim;
    mv  = int'(max_val);
    lim = 1 << W;
    m_tcu[m] = 0;
    m_tcd[m] = 0;
    if (reset) begin
      m_cnt[m] = 0; m_ovf[m] = 0; m_dir[m] = 0;
      return;
    end
    if (load) begin
      m_cnt[m] = int'(load_val); m_dir[m] = 3;
    end else if (up) begin
      m_dir[m] = 1;
      if (m_cnt[m] < mv) m_cnt[m] = (m_cnt[m] + 1) % lim;
      else begin m_tcu[m] = 1; m_cnt[m] = (m == 1) ? mv : 0; end
    end else if (down) begin
      m_dir[m] = 2;
      if (m_cnt[m] > 0) m_cnt[m] = (m_cnt[m] - 1 + lim) % lim;
      else begin m_tcd[m] = 1; m_cnt[m] = (m == 1) ? 0 : mv; end
    end else m_dir[m] = 0;
    if (m_tcu[m] == 1 || m_tcd[m] == 1) m_ovf[m] = 1;
    else if (clr_ovf)                   m_ovf[m] = 0;
  endtask

  // Apply inputs for one cycle, advance the model, compare #1 after the edge.
  task automatic cyc(input logic r, input logic u, input logic d, input logic l,
                     input logic [W-1:0] lv, input logic [W-1:0] mv, input logic co);
    reset = r; up = u; down = d; load = l; load_val = lv; max_val = mv; clr_ovf = co;
    @(posedge clk);
    model(0);
    model(1);
    #1;
    chk("w.count", 32'(cnt0), 32'(m_cnt[0]));
    chk("w.tc_up", 32'(tcu0), 32'(m_tcu[0]));
    chk("w.tc_down", 32'(tcd0), 32'(m_tcd[0]));
    chk("w.ovf", 32'(ovf0), 32'(m_ovf[0]));
    chk("w.dir", 32'(dir0), 32'(m_dir[0]));
    chk("s.count", 32'(cnt1), 32'(m_cnt[1]));
    chk("s.tc_up", 32'(tcu1), 32'(m_tcu[1]));
    chk("s.tc_down", 32'(tcd1), 32'(m_tcd[1]));
    chk("s.ovf", 32'(ovf1), 32'(m_ovf[1]));
    chk("s.dir", 32'(dir1), 32'(m_dir[1]));
  endtask

  initial begin
    // reset for two cycles
    cyc(1, 0, 0, 0, 0, 15, 0);
    cyc(1, 0, 0, 0, 0, 15, 0);
    chk("rst.count", 32'(cnt0), 0);
    chk("rst.tc", 32'({tcu0, tcd0}), 0);
    chk("rst.ovf", 32'(ovf0), 0);
    chk("rst.dir", 32'(dir0), 0);

    // wrap count through full range
    for (int i = 1; i <= 15; i++) begin
      cyc(0, 1, 0, 0, 0, 15, 0);
      chk("wrap.count", 32'(cnt0), 32'(i));
      chk("wrap.tc_up", 32'(tcu0), 0);
    end
    cyc(0, 1, 0, 0, 0, 15, 0);
    chk("wrap.count0", 32'(cnt0), 0);
    chk("wrap.tc_up1", 32'(tcu0), 1);
    cyc(0, 0, 0, 0, 0, 15, 0);
    chk("wrap.ovf", 32'(ovf0), 1);
    chk("wrap.tc_off", 32'(tcu0), 0);

    // saturate at 9
    cyc(1, 0, 0, 0, 0, 9, 0);
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 1, 0, 0, 0, 9, 0);
      chk("sat.count", 32'(cnt1), 32'(i > 9 ? 9 : i));
      chk("sat.tc_up", 32'(tcu1), 32'(i > 9 ? 1 : 0));
    end
    cyc(0, 0, 1, 0, 0, 9, 0);
    chk("sat.down", 32'(cnt1), 8);
    chk("sat.down_tc", 32'(tcu1), 0);

    // up beats down, load beats up
    cyc(1, 0, 0, 0, 0, 15, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 15, 0);
    cyc(0, 1, 1, 0, 0, 15, 0);
    chk("updn.count", 32'(cnt0), 6);
    chk("updn.dir", 32'(dir0), 1);
    cyc(0, 1, 0, 1, 12, 15, 0);
    chk("load.count", 32'(cnt0), 12);
    chk("load.dir", 32'(dir0), 3);
    chk("load.tc", 32'({tcu0, tcd0}), 0);

    // wrap down from 0 to max
    cyc(1, 0, 0, 0, 0, 9, 0);
    cyc(0, 0, 1, 0, 0, 9, 0);
    chk("wdn.count", 32'(cnt0), 9);
    chk("wdn.tc_down", 32'(tcd0), 1);
    chk("wdn.dir", 32'(dir0), 2);
    chk("sdn.count", 32'(cnt1), 0);

    // clr_ovf against a same-cycle event, then alone
    cyc(0, 0, 0, 0, 0, 9, 1);
    chk("clr.ovf0", 32'(ovf0), 0);
    cyc(0, 1, 0, 0, 0, 9, 1);
    chk("clr.tc_up", 32'(tcu0), 1);
    chk("clr.ovf_set_wins", 32'(ovf0), 1);
    cyc(0, 0, 0, 0, 0, 9, 1);
    chk("clr.ovf_clr", 32'(ovf0), 0);

    // max_val 0 with up
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("max0.count", 32'(cnt0), 0);
    chk("max0.tc_up", 32'(tcu0), 1);

    // reset mid-count with ovf set
    cyc(0, 1, 0, 1, 0, 15, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 15, 0);
    chk("mid.count7", 32'(cnt0), 7);
    chk("mid.ovf_pre", 32'(ovf0), 1);
    cyc(1, 1, 0, 0, 0, 15, 0);
    chk("mid.count", 32'(cnt0), 0);
    chk("mid.ovf", 32'(ovf0), 0);
    chk("mid.dir", 32'(dir0), 0);
    chk("mid.tc", 32'({tcu0, tcd0}), 0);
    cyc(0, 0, 0, 0, 0, 15, 0);
    chk("mid.no_resid", 32'({tcu0, tcd0}), 0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1,
          $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
          W'($urandom), (($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom)),
          ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter MODE, default 0: boundary behaviour, 0 = wrap, 1 = saturate.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 up  input  1  count-up request.
REQ-006 down  input  1  count-down request.
REQ-007 load  input  1  parallel-load strobe.
REQ-008 load_val  input  WIDTH  value written on load.
REQ-009 max_val  input  WIDTH  upper count bound; sampled every cycle.
REQ-010 clr_ovf  input  1  clears the sticky overflow flag.
REQ-011 count  output  WIDTH  current count, registered.
REQ-012 tc_up  output  1  one-cycle pulse on an upper-boundary event.
REQ-013 tc_down  output  1  one-cycle pulse on a lower-boundary event.
REQ-014 ovf  output  1  sticky flag for any boundary event.
REQ-015 dir  output  2  last action: 00 IDLE, 01 UP, 10 DOWN, 11 LOAD.

Function
REQ-016 Each cycle SHALL apply exactly one action, in priority order: reset > load > up > down > hold.
REQ-017 up=1 SHALL count up regardless of down; down SHALL take effect only when up=0 and load=0.
REQ-018 Up, count<max_val: count SHALL become count+1 on the next edge.
REQ-019 Up, count>=max_val: the next count SHALL be 0 when MODE=0 and max_val when MODE=1; tc_up=1 for that cycle.
REQ-020 Down, count>0: count SHALL become count-1.
REQ-021 Down, count==0: the next count SHALL be max_val when MODE=0 and 0 (hold) when MODE=1; tc_down=1 for that cycle.
REQ-022 Load SHALL write load_val unchanged, even if it exceeds max_val; no tc pulse, ovf unaffected.
REQ-023 tc_up/tc_down SHALL be registered, asserted in the same cycle count shows the post-event value, and deasserted the following cycle unless the event repeats.
REQ-024 ovf SHALL set on any tc_up or tc_down event and clear on clr_ovf; when both occur in the same cycle, set SHALL win.
REQ-025 dir SHALL be a 4-state registered FSM; each edge it SHALL move to the state of the action applied (IDLE on hold); every transition between any two states is legal.
REQ-026 max_val=0: up SHALL keep count at 0 and pulse tc_up every cycle; down SHALL behave per REQ-021.
REQ-027 All arithmetic SHALL be modulo 2^WIDTH, with no internal carry beyond WIDTH bits.

Reset
REQ-028 When reset=1 at an edge: count=0, tc_up=0, tc_down=0, ovf=0, dir=IDLE; all other inputs ignored that cycle.
REQ-029 Reset asserted mid-count SHALL take effect at the next edge with no residual pulse afterwards.
REQ-030 Reset is synchronous only: before the first reset edge outputs are undefined, and the bench SHALL NOT check them.

Structure
REQ-031 A shared package updown_pkg SHALL hold the dir state encoding and the MODE constants (MODE_WRAP=0, MODE_SAT=1).
REQ-032 The next-count and boundary-detect logic SHALL live in one combinational sub-module updown_next, with registers kept in updown_counter_n.

Verification (WIDTH=4)
REQ-033 The bench SHALL drive reset=1 for 2 cycles, then up=1 with max_val=15 and MODE=0, and SHALL check count 0,1..15,0, tc_up=1 only on the cycle with count 0 after 15, and ovf=1 afterwards.
REQ-034 The bench SHALL set MODE=1 and max_val=9, hold up=1 from 0, and SHALL check count saturates at 9, tc_up pulses every cycle at the bound, then down=1 gives 8.
REQ-035 The bench SHALL drive up=1 and down=1 together at count 5 and SHALL check 6; then load=1, load_val=12, up=1 and SHALL check 12 with dir=LOAD and no tc.
REQ-036 The bench SHALL set MODE=0, max_val=9, count=0, and drive down=1, and SHALL check count 9, tc_down=1, and dir=DOWN.
REQ-037 The bench SHALL drive clr_ovf=1 in the same cycle as a tc_up event and SHALL check ovf stays 1; clr_ovf alone on the next cycle SHALL give ovf=0.
REQ-038 The bench SHALL assert reset=1 at count 7 with up=1, and SHALL check count=0, ovf=0, dir=IDLE on the next edge with no tc pulse.
